// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regfile write port between the writeback stage and a queued mul/div unit,
// with a starvation guard and a per-register busy scoreboard for long-latency results.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wd,
  output logic        wb_hold,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_wd,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic        sb_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0]    r_fq_rd [DEPTH];
  logic [31:0]   r_fq_wd [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_busy;
  logic          r_hold, r_err;
  logic          w_take, w_push, w_pop, w_empty, w_inc, w_steal, w_err;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_set, w_clr;
  assign wb_hold   = r_hold;
  assign sb_err    = r_err;
  assign w_empty   = r_cnt == '0;
  assign md_ready  = r_cnt != (AW+1)'(DEPTH);
  assign w_head_rd = r_fq_rd[r_rp];
  assign w_take    = wb_we & ~r_hold & (wb_rd != 5'd0);
  assign w_push    = md_valid & md_ready & (md_rd != 5'd0);
  assign w_pop     = ~w_take & ~w_empty;
  // the queue is blocked whenever the pipeline wins the port while results are waiting
  assign w_inc     = w_take & ~w_empty;
  assign w_steal   = w_inc & (r_starve == SW'(STARVE_MAX - 1));
  assign rf_we     = w_take | w_pop;
  assign rf_a3     = w_take ? wb_rd : w_pop ? w_head_rd : 5'd0;
  assign rf_wd     = w_take ? wb_wd : w_pop ? r_fq_wd[r_rp] : 32'd0;
  assign w_set     = (iss_valid && iss_rd != 5'd0) ? 32'd1 << iss_rd : 32'd0;
  assign w_clr     = w_pop ? 32'd1 << w_head_rd : 32'd0;
  assign w_err     = (|(w_set & r_busy & ~w_clr)) | (w_push & ~r_busy[md_rd]);
  assign q_busy1   = (q_rs1 != 5'd0) & r_busy[q_rs1];
  assign q_busy2   = (q_rs2 != 5'd0) & r_busy[q_rs2];
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fq_rd[r_wp] <= md_rd;
      r_fq_wd[r_wp] <= md_wd;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_busy   <= '0;
      r_hold   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wp     <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp     <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt    <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_starve <= (w_pop | w_steal) ? '0 : w_inc ? r_starve + 1'b1 : r_starve;
      r_hold   <= w_steal;
      r_busy   <= (r_busy & ~w_clr) | w_set;
      r_err    <= r_err | w_err;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table with a queue of expected write-port values per cycle
module tb_wb_port_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        wb_we = 0, md_valid = 0, iss_valid = 0;
  logic [4:0]  wb_rd = 0, md_rd = 0, iss_rd = 0, q_rs1 = 0, q_rs2 = 0;
  logic [31:0] wb_wd = 0, md_wd = 0;
  logic        wb_hold, md_ready, q_busy1, q_busy2, rf_we, sb_err;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  typedef struct {
    string nm; bit rst;
    bit wb_we; logic [4:0] wb_rd; logic [31:0] wb_wd;
    bit md_v; logic [4:0] md_rd; logic [31:0] md_wd;
    bit iss_v; logic [4:0] iss_rd; logic [4:0] q1, q2;
    logic [37:0] e_rf; logic [4:0] e_flags;
  } vec_t;
  vec_t        tv[$];
  logic [37:0] q_rf[$];
  logic [37:0] m_e;
  string       cur_nm = "";
  int          total = 0, bad = 0;
  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .wb_hold(wb_hold),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_wd(md_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
    .q_busy1(q_busy1), .q_busy2(q_busy2), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .sb_err(sb_err)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(string nm, bit rst, bit ww, int wr, int wd, bit mv, int mr, int mdd,
                              bit iv, int ir, int q1, int q2, bit ew, int ea, int ewd,
                              bit eh, bit er, bit eb1, bit eb2, bit ee);
    vec_t v;
    v.nm = nm; v.rst = rst;
    v.wb_we = ww; v.wb_rd = 5'(wr); v.wb_wd = wd;
    v.md_v = mv; v.md_rd = 5'(mr); v.md_wd = mdd;
    v.iss_v = iv; v.iss_rd = 5'(ir); v.q1 = 5'(q1); v.q2 = 5'(q2);
    v.e_rf = {ew, 5'(ea), 32'(ewd)};
    v.e_flags = {eh, er, eb1, eb2, ee};
    return v;
  endfunction
  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    if (v.rst) begin
      reset = 1; wb_we = 0; md_valid = 0; iss_valid = 0;
      @(posedge clk); #1;
      reset = 0;
    end
    cur_nm = v.nm;
    wb_we = v.wb_we; wb_rd = v.wb_rd; wb_wd = v.wb_wd;
    md_valid = v.md_v; md_rd = v.md_rd; md_wd = v.md_wd;
    iss_valid = v.iss_v; iss_rd = v.iss_rd; q_rs1 = v.q1; q_rs2 = v.q2;
    q_rf.push_back(v.e_rf);
    @(negedge clk);
    total++;
    if ({wb_hold, md_ready, q_busy1, q_busy2, sb_err} !== v.e_flags) begin
      bad++;
      $display("FAIL flags %s: got hold,rdy,b1,b2,err=%b want %b", v.nm,
               {wb_hold, md_ready, q_busy1, q_busy2, sb_err}, v.e_flags);
    end
  endtask
  always @(negedge clk) begin
    if (q_rf.size() != 0) begin
      m_e = q_rf.pop_front();
      total++;
      if ({rf_we, rf_a3, rf_wd} !== m_e) begin
        bad++;
        $display("FAIL rf %s: got we=%b a3=%0d wd=%h want we=%b a3=%0d wd=%h", cur_nm,
                 rf_we, rf_a3, rf_wd, m_e[37], m_e[36:32], m_e[31:0]);
      end
      total++;
      if (rf_we && rf_a3 == 5'd0) begin
        bad++;
        $display("FAIL x0_write %s: got a3=0 with we=1 want no write", cur_nm);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
  initial begin
    //            name     rst we rd  wd       mv rd  wd            iv rd  q1  q2  ew a3  wd          h  r  b1 b2 e
    tv.push_back(mk("rst",    1, 0, 0, 0,       0, 0, 0,            0, 0,  5,  0,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss5",   0, 0, 0, 0,       0, 0, 0,            1, 5,  5,  0,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("busy5a", 0, 0, 0, 0,       0, 0, 0,            0, 0,  5,  0,  0, 0,  0,           0, 1, 1, 0, 0));
    tv.push_back(mk("busy5b", 0, 0, 0, 0,       0, 0, 0,            0, 0,  5,  0,  0, 0,  0,           0, 1, 1, 0, 0));
    tv.push_back(mk("md5",    0, 0, 0, 0,       1, 5, 32'hDEADBEEF, 0, 0,  5,  0,  0, 0,  0,           0, 1, 1, 0, 0));
    tv.push_back(mk("wr5",    0, 0, 0, 0,       0, 0, 0,            0, 0,  5,  0,  1, 5,  32'hDEADBEEF,0, 1, 1, 0, 0));
    tv.push_back(mk("clr5",   0, 0, 0, 0,       0, 0, 0,            0, 0,  5,  0,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss10",  0, 0, 0, 0,       0, 0, 0,            1, 10, 10, 11, 0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss11",  0, 0, 0, 0,       0, 0, 0,            1, 11, 10, 11, 0, 0,  0,           0, 1, 1, 0, 0));
    tv.push_back(mk("st_x1",  0, 1, 1, 'h101,   1, 10, 'hA10,       0, 0,  10, 11, 1, 1,  'h101,       0, 1, 1, 1, 0));
    tv.push_back(mk("st_x2",  0, 1, 2, 'h102,   1, 11, 'hA11,       0, 0,  10, 11, 1, 2,  'h102,       0, 1, 1, 1, 0));
    tv.push_back(mk("st_x3",  0, 1, 3, 'h103,   0, 0, 0,            0, 0,  10, 11, 1, 3,  'h103,       0, 0, 1, 1, 0));
    tv.push_back(mk("st_x4",  0, 1, 4, 'h104,   0, 0, 0,            0, 0,  10, 11, 1, 4,  'h104,       0, 0, 1, 1, 0));
    tv.push_back(mk("st_x5",  0, 1, 5, 'h105,   0, 0, 0,            0, 0,  10, 11, 1, 5,  'h105,       0, 0, 1, 1, 0));
    tv.push_back(mk("hold",   0, 1, 6, 'h106,   0, 0, 0,            0, 0,  10, 11, 1, 10, 'hA10,       1, 0, 1, 1, 0));
    tv.push_back(mk("rep_x6", 0, 1, 6, 'h106,   0, 0, 0,            0, 0,  10, 11, 1, 6,  'h106,       0, 1, 0, 1, 0));
    tv.push_back(mk("st_x7",  0, 1, 7, 'h107,   0, 0, 0,            0, 0,  10, 11, 1, 7,  'h107,       0, 1, 0, 1, 0));
    tv.push_back(mk("st_x8",  0, 1, 8, 'h108,   0, 0, 0,            0, 0,  10, 11, 1, 8,  'h108,       0, 1, 0, 1, 0));
    tv.push_back(mk("wr11",   0, 0, 0, 0,       0, 0, 0,            0, 0,  10, 11, 1, 11, 'hA11,       0, 1, 0, 1, 0));
    tv.push_back(mk("clr11",  0, 0, 0, 0,       0, 0, 0,            0, 0,  10, 11, 0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss12",  0, 0, 0, 0,       0, 0, 0,            1, 12, 12, 0,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("md12",   0, 0, 0, 0,       1, 12, 'hC12,       0, 0,  12, 0,  0, 0,  0,           0, 1, 1, 0, 0));
    tv.push_back(mk("wbx0",   0, 1, 0, 'hFFFF,  0, 0, 0,            0, 0,  12, 0,  1, 12, 'hC12,       0, 1, 1, 0, 0));
    tv.push_back(mk("mdx0",   0, 0, 0, 0,       1, 0, 'h123,        0, 0,  12, 0,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("mdx0_nq",0, 0, 0, 0,       0, 0, 0,            0, 0,  12, 0,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("wbx0_i", 0, 1, 0, 'h55,    0, 0, 0,            0, 0,  12, 0,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss13",  0, 0, 0, 0,       0, 0, 0,            1, 13, 15, 16, 0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss14",  0, 0, 0, 0,       0, 0, 0,            1, 14, 15, 16, 0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss15",  0, 0, 0, 0,       0, 0, 0,            1, 15, 15, 16, 0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss16",  0, 0, 0, 0,       0, 0, 0,            1, 16, 15, 16, 0, 0,  0,           0, 1, 1, 0, 0));
    tv.push_back(mk("fill13", 0, 1, 20, 'h220,  1, 13, 'hD13,       0, 0,  15, 16, 1, 20, 'h220,       0, 1, 1, 1, 0));
    tv.push_back(mk("fill14", 0, 1, 21, 'h221,  1, 14, 'hD14,       0, 0,  15, 16, 1, 21, 'h221,       0, 1, 1, 1, 0));
    tv.push_back(mk("full",   0, 0, 0, 0,       1, 15, 'hD15,       0, 0,  15, 16, 1, 13, 'hD13,       0, 0, 1, 1, 0));
    tv.push_back(mk("pp15",   0, 0, 0, 0,       1, 15, 'hD15,       0, 0,  15, 16, 1, 14, 'hD14,       0, 1, 1, 1, 0));
    tv.push_back(mk("pp16",   0, 0, 0, 0,       1, 16, 'hD16,       0, 0,  15, 16, 1, 15, 'hD15,       0, 1, 1, 1, 0));
    tv.push_back(mk("wr16",   0, 0, 0, 0,       0, 0, 0,            0, 0,  15, 16, 1, 16, 'hD16,       0, 1, 0, 1, 0));
    tv.push_back(mk("drained",0, 0, 0, 0,       0, 0, 0,            0, 0,  15, 16, 0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss7",   0, 0, 0, 0,       0, 0, 0,            1, 7,  7,  0,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("iss7x2", 0, 0, 0, 0,       0, 0, 0,            1, 7,  7,  0,  0, 0,  0,           0, 1, 1, 0, 0));
    tv.push_back(mk("err7",   0, 0, 0, 0,       0, 0, 0,            0, 0,  7,  0,  0, 0,  0,           0, 1, 1, 0, 1));
    tv.push_back(mk("sticky", 0, 0, 0, 0,       0, 0, 0,            0, 0,  7,  0,  0, 0,  0,           0, 1, 1, 0, 1));
    tv.push_back(mk("iss17",  0, 0, 0, 0,       0, 0, 0,            1, 17, 17, 7,  0, 0,  0,           0, 1, 0, 1, 1));
    tv.push_back(mk("q17",    0, 1, 22, 'h222,  1, 17, 'hE17,       0, 0,  17, 7,  1, 22, 'h222,       0, 1, 1, 1, 1));
    tv.push_back(mk("rst_mid",1, 0, 0, 0,       0, 0, 0,            0, 0,  17, 7,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("md9",    0, 0, 0, 0,       1, 9, 'h999,        0, 0,  9,  0,  0, 0,  0,           0, 1, 0, 0, 0));
    tv.push_back(mk("err9",   0, 0, 0, 0,       0, 0, 0,            0, 0,  9,  0,  1, 9,  'h999,       0, 1, 0, 0, 1));
    tv.push_back(mk("err9_st",0, 0, 0, 0,       0, 0, 0,            0, 0,  9,  0,  0, 0,  0,           0, 1, 0, 0, 1));
    repeat (2) @(posedge clk);
    for (int i = 0; i < tv.size(); i++) apply(tv[i]);
    @(posedge clk); #1;
    total++;
    if (q_rf.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending want 0", q_rf.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
